ycr2_mem_arb: RTL and testbench
===============================

YCR2_MEM_ARB -- requirements
Module: ycr2_mem_arb

Interface
REQ-001 Parameter: TMO_W, 8, width of the burst timeout counter (used only when YCR2_ARB_TMO_EN is defined).
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  4  requests; bit0 core0_imem, bit1 core0_dmem, bit2 core1_imem, bit3 core1_dmem.
REQ-005 Port: req_ack  input  1  target accepted the current command beat.
REQ-006 Port: lack  input  1  target last-beat response; ends the transaction.
REQ-007 Port: gnt  output  2  encoded index of the granted requester.
REQ-008 Port: gnt_vld  output  1  gnt is valid and the shared path is owned.
REQ-009 Port: busy  output  1  FSM not in IDLE.
REQ-010 Port: tmo_err  output  1  one-cycle pulse on burst timeout.

Function
REQ-011 The FSM SHALL have three states: IDLE, CMD (grant issued, awaiting req_ack) and DATA (accepted, awaiting lack).
REQ-012 IDLE, req!=0: SHALL register the round-robin winner into gnt, set gnt_vld and enter CMD next cycle; the request-to-gnt_vld latency is 1 cycle.
REQ-013 Round-robin search order SHALL start at last_ptr+1 modulo 4 and wrap, so the most recently served requester has lowest priority.
REQ-014 last_ptr SHALL update to gnt only when a transaction completes (lack or timeout), not on abort.
REQ-015 CMD, req[gnt]=0 and req_ack=0: SHALL abort to IDLE and clear gnt_vld the next cycle.
REQ-016 CMD, req_ack=1 and lack=1 in the same cycle: SHALL go to IDLE; otherwise, on req_ack=1, SHALL go to DATA.
REQ-017 DATA: SHALL hold gnt and gnt_vld stable, ignore req changes, and go to IDLE on lack=1.
REQ-018 gnt SHALL NOT change while gnt_vld=1; gnt_vld SHALL be 0 in IDLE.
REQ-019 After every return to IDLE there SHALL be exactly one IDLE cycle before the next grant; that bubble is required behaviour.
REQ-020 lack in IDLE, and lack in CMD without req_ack, SHALL be ignored.
REQ-021 busy SHALL be 1 in CMD and DATA; tmo_err SHALL be 0 except as given in REQ-026.

Reset
REQ-022 rst_n=0 sampled on a clock edge SHALL force IDLE, gnt=0, gnt_vld=0, busy=0, tmo_err=0, last_ptr=3 (requester 0 wins first), and timeout counter=0.
REQ-023 Reset asserted mid-transaction SHALL drop the grant with no completion and no last_ptr update from that transaction.

Configuration
REQ-024 Macro YCR2_ARB_TMO_EN SHALL enable the burst timeout watchdog.
REQ-025 Defined: the counter SHALL clear on entry to DATA and increment each DATA cycle without lack.
REQ-026 Defined: when the counter reaches 2^TMO_W-1 without lack, the FSM SHALL go to IDLE, pulse tmo_err for 1 cycle and advance last_ptr; lack in that same cycle takes precedence and tmo_err stays 0.
REQ-027 Undefined: no counter SHALL exist, tmo_err SHALL be tied 0, and DATA waits indefinitely.

Structure
REQ-028 Package ycr2_arb_pkg SHALL hold the state enum type (IDLE/CMD/DATA) and the constant YCR2_ARB_NREQ=4.
REQ-029 Sub-module ycr2_rr_pick SHALL be the combinational rotate-priority-encoder: inputs req and last_ptr; outputs winner index and any-valid flag.
REQ-030 The block SHALL contain no datapath muxing; the router consumes gnt/gnt_vld.

Verification
REQ-031 Reset release, req=4'b1111 -> gnt=0 one cycle later; after req_ack+lack on each, grants follow the order 0,1,2,3,0.
REQ-032 req=4'b0100 only, req_ack in cycle 2, lack in cycle 5 -> gnt=2 and gnt_vld=1 stable over cycles 1-5, IDLE in cycle 6, busy=0.
REQ-033 Grant to 1 in CMD, req[1] drops before req_ack -> IDLE; with req=4'b0011 the next grant is 0 (last_ptr unchanged at 3).
REQ-034 req_ack and lack together in CMD -> IDLE next cycle; a pending req=4'b1000 is granted after one bubble cycle.
REQ-035 YCR2_ARB_TMO_EN, TMO_W=4, no lack in DATA -> tmo_err pulses on the 15th DATA cycle, FSM goes to IDLE, the next grant skips the timed-out requester; lack on the 15th cycle -> no tmo_err.
REQ-036 rst_n=0 for one cycle while in DATA with gnt=3 -> gnt_vld=0 and gnt=0 next cycle; with req=4'b1001 the next grant is 0.

Source files
------------

// File: rtl/ycr2_mem_arb_pkg.sv
// Shared types and constants for the ycr2 memory arbiter.
package ycr2_arb_pkg;

    localparam int unsigned YCR2_ARB_NREQ  = 4;
    localparam int unsigned YCR2_ARB_IDX_W = $clog2(YCR2_ARB_NREQ);

    typedef logic [YCR2_ARB_IDX_W-1:0] arb_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } arb_state_e;

endpackage

// File: rtl/ycr2_mem_arb_if.sv
// Request/grant bundle between the requesters/target and the arbiter.
interface ycr2_mem_arb_if;
    import ycr2_arb_pkg::*;

    logic [YCR2_ARB_NREQ-1:0] req;
    logic                     req_ack;
    logic                     lack;
    arb_idx_t                 gnt;
    logic                     gnt_vld;
    logic                     busy;
    logic                     tmo_err;

    // Requesters and target side.
    modport master (
        output req, req_ack, lack,
        input  gnt, gnt_vld, busy, tmo_err
    );

    // Arbiter side.
    modport slave (
        input  req, req_ack, lack,
        output gnt, gnt_vld, busy, tmo_err
    );

endinterface

// File: rtl/ycr2_rr_pick.sv
// Rotating priority encoder: search starts one past last_ptr and wraps.
module ycr2_rr_pick
    import ycr2_arb_pkg::*;
(
    input  logic [YCR2_ARB_NREQ-1:0] req,
    input  arb_idx_t                 last_ptr,
    output arb_idx_t                 winner,
    output logic                     any
);

    arb_idx_t idx;
    logic     found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // last_ptr itself is visited last, giving it the lowest priority.
        for (int i = 1; i <= int'(YCR2_ARB_NREQ); i++) begin
            idx = last_ptr + arb_idx_t'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/ycr2_mem_arb.sv
// Round-robin grant FSM for the shared memory path (IDLE -> CMD -> DATA).
// Define YCR2_ARB_TMO_EN to enable the DATA-phase burst timeout watchdog.
module ycr2_mem_arb
    import ycr2_arb_pkg::*;
#(
    parameter int unsigned TMO_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    ycr2_mem_arb_if.slave bus
);

    arb_state_e state_q, state_d;
    arb_idx_t   gnt_q;
    arb_idx_t   last_ptr_q;
    arb_idx_t   winner;
    logic       any;
    logic       tmo_hit;
    logic       done;

    ycr2_rr_pick u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .winner   (winner),
        .any      (any)
    );

`ifdef YCR2_ARB_TMO_EN
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StCmd && state_d == StData) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StData && !bus.lack) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Fires on the cycle whose increment would reach the all-ones count.
    assign tmo_hit = (state_q == StData) && !bus.lack && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = (state_q == StCmd  && bus.req_ack && bus.lack) ||
                  (state_q == StData && (bus.lack || tmo_hit));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            last_ptr_q <= arb_idx_t'(YCR2_ARB_NREQ - 1);
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && any) begin
                gnt_q <= winner;
            end
            if (done) begin
                last_ptr_q <= gnt_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any) state_d = StCmd;
            end
            StCmd: begin
                if (bus.req_ack) begin
                    state_d = bus.lack ? StIdle : StData;
                end else if (!bus.req[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (bus.lack || tmo_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.gnt     = gnt_q;
        bus.gnt_vld = (state_q != StIdle);
        bus.busy    = (state_q != StIdle);
        bus.tmo_err = tmo_hit;
    end

endmodule

// File: tb/tb_ycr2_mem_arb.sv
// Directed self-checking bench for ycr2_mem_arb; timeout cases need YCR2_ARB_TMO_EN.
module tb_ycr2_mem_arb;
    import ycr2_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    ycr2_mem_arb_if bus_if ();

    ycr2_mem_arb #(
        .TMO_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic a, input logic l);
        bus_if.req     = r;
        bus_if.req_ack = a;
        bus_if.lack    = l;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"}, int'(bus_if.gnt_vld), 0);
        check({tag, "_busy"}, int'(bus_if.busy), 0);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state, checked while reset is still asserted.
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        step();
        step();
        check("rst_gnt", int'(bus_if.gnt), 0);
        check_idle("rst");
        check("rst_tmo", int'(bus_if.tmo_err), 0);
        rst_n = 1'b1;

        // Lack in IDLE is ignored.
        drive(4'b0000, 1'b0, 1'b1);
        step();
        check_idle("idle_lack");

        // All requesting: grants rotate 0,1,2,3,0.
        drive(4'b1111, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_gnt%0d", k), int'(bus_if.gnt), order[k]);
            check($sformatf("rr_vld%0d", k), int'(bus_if.gnt_vld), 1);
            drive(4'b1111, 1'b1, 1'b1);
            step();
            check_idle($sformatf("rr_bubble%0d", k));
            drive(4'b1111, 1'b0, 1'b0);
            step();
        end

        // Single requester 2: stable grant through CMD and DATA.
        do_reset();
        drive(4'b0100, 1'b0, 1'b0);
        step();
        check("c1_gnt", int'(bus_if.gnt), 2);
        check("c1_vld", int'(bus_if.gnt_vld), 1);
        drive(4'b0100, 1'b0, 1'b1);                 // lack without ack in CMD
        step();
        check("c2_gnt", int'(bus_if.gnt), 2);
        check("c2_vld", int'(bus_if.gnt_vld), 1);
        drive(4'b0100, 1'b1, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b0);                 // req drop in DATA is ignored
        check("c3_gnt", int'(bus_if.gnt), 2);
        check("c3_busy", int'(bus_if.busy), 1);
        step();
        check("c4_vld", int'(bus_if.gnt_vld), 1);
        step();
        check("c5_gnt", int'(bus_if.gnt), 2);
        check("c5_vld", int'(bus_if.gnt_vld), 1);
        drive(4'b0000, 1'b0, 1'b1);
        step();
        drive(4'b0000, 1'b0, 1'b0);
        check_idle("c6");

        // Abort in CMD leaves last_ptr at 3.
        do_reset();
        drive(4'b0010, 1'b0, 1'b0);
        step();
        check("ab_gnt1", int'(bus_if.gnt), 1);
        drive(4'b0001, 1'b0, 1'b0);
        step();
        check_idle("ab_idle");
        drive(4'b0011, 1'b0, 1'b0);
        step();
        check("ab_next", int'(bus_if.gnt), 0);
        drive(4'b0000, 1'b0, 1'b0);
        step();
        check_idle("ab_idle2");
        drive(4'b0110, 1'b0, 1'b0);
        step();
        check("ab_ptr3", int'(bus_if.gnt), 1);

        // Ack and lack together in CMD, then one bubble before the next grant.
        do_reset();
        drive(4'b0001, 1'b0, 1'b0);
        step();
        check("al_gnt0", int'(bus_if.gnt), 0);
        drive(4'b1000, 1'b1, 1'b1);
        step();
        check_idle("al_bubble");
        drive(4'b1000, 1'b0, 1'b0);
        step();
        check("al_gnt3", int'(bus_if.gnt), 3);
        check("al_vld3", int'(bus_if.gnt_vld), 1);

        // Reset during DATA drops the grant.
        drive(4'b1000, 1'b1, 1'b0);
        step();
        drive(4'b1000, 1'b0, 1'b0);
        check("rd_busy", int'(bus_if.busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rd_vld", int'(bus_if.gnt_vld), 0);
        check("rd_gnt", int'(bus_if.gnt), 0);
        drive(4'b1001, 1'b0, 1'b0);
        step();
        check("rd_next", int'(bus_if.gnt), 0);

`ifdef YCR2_ARB_TMO_EN
        // Timeout on the 15th DATA cycle, then the timed-out requester is skipped.
        do_reset();
        drive(4'b0001, 1'b0, 1'b0);
        step();
        drive(4'b0001, 1'b1, 1'b0);
        step();
        drive(4'b0001, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("to_err%0d", k), int'(bus_if.tmo_err), (k == 15) ? 1 : 0);
            if (k < 15) step();
        end
        drive(4'b0011, 1'b0, 1'b0);
        step();
        check_idle("to_idle");
        check("to_pulse", int'(bus_if.tmo_err), 0);
        step();
        check("to_skip", int'(bus_if.gnt), 1);

        // Lack on the 15th DATA cycle wins over the timeout.
        do_reset();
        drive(4'b0001, 1'b0, 1'b0);
        step();
        drive(4'b0001, 1'b1, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b0);
        for (int k = 1; k < 15; k++) step();
        drive(4'b0000, 1'b0, 1'b1);
        check("tl_err", int'(bus_if.tmo_err), 0);
        step();
        drive(4'b0000, 1'b0, 1'b0);
        check_idle("tl_idle");
`else
        // Without the watchdog DATA waits indefinitely and tmo_err stays low.
        do_reset();
        drive(4'b0001, 1'b0, 1'b0);
        step();
        drive(4'b0001, 1'b1, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) step();
        check("nt_busy", int'(bus_if.busy), 1);
        check("nt_err", int'(bus_if.tmo_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
